// File: rtl/johnson_seq_ctrl.sv
// Johnson (twisted-ring) counter sequencer with start/done handshake, hold, abort and checked parallel load.
// Define JC_PHASE_DECODE_EN to add the one-hot phase_oh output decoded from adjacent Q bit pairs.
module johnson_seq_ctrl #(
    parameter int BITS  = 4,
    parameter int CNT_W = 8,
    parameter int IDX_W = $clog2(2*BITS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic             hold,
    input  logic             abort,
    input  logic             load,
    input  logic [BITS-1:0]  load_val,
    input  logic             err_clr,
    output logic [BITS-1:0]  Q,
    output logic [IDX_W-1:0] phase_idx,
    output logic             busy,
    output logic             done,
    output logic             wrap,
`ifdef JC_PHASE_DECODE_EN
    output logic [2*BITS-1:0] phase_oh,
`endif
    output logic             err
);

    localparam int TWO_B = 2 * BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [BITS-1:0]  q_q, q_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [BITS-1:0]  fwdNext;
    logic [BITS-1:0]  revNext;
    logic [BITS-1:0]  advNext;
    logic             loadLegal;
    logic             qLegal;
    logic [IDX_W:0]   popCnt;
    logic [IDX_W:0]   idxWide;

    // A legal Johnson value has at most one place where neighbouring bits differ.
    function automatic logic isLegal(input logic [BITS-1:0] v);
        int edges;
        edges = 0;
        for (int i = 0; i < BITS - 1; i++) begin
            if (v[i] != v[i+1]) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

    assign fwdNext   = {~q_q[0], q_q[BITS-1:1]};
    assign revNext   = {q_q[BITS-2:0], ~q_q[BITS-1]};
    assign advNext   = dir_q ? revNext : fwdNext;
    assign loadLegal = isLegal(load_val);
    assign qLegal    = isLegal(q_q);

    always_comb begin
        popCnt = '0;
        for (int i = 0; i < BITS; i++) begin
            popCnt = popCnt + {{IDX_W{1'b0}}, q_q[i]};
        end
    end

    // Upper half of the cycle (MSB cleared, Q non-zero) counts down from 2*BITS.
    always_comb begin
        if (q_q[BITS-1] || (q_q == '0)) begin
            idxWide = popCnt;
        end else begin
            idxWide = (IDX_W+1)'(TWO_B) - popCnt;
        end
    end

    assign phase_idx = idxWide[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        wrap_d      = 1'b0;
        err_d       = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (steps != '0) begin
                        remaining_d = steps;
                        dir_d       = dir;
                        state_d     = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (load) begin
                    // An illegal load parks Q at phase 0; the error set overrides a same-edge clear.
                    if (loadLegal) begin
                        q_d = load_val;
                    end else begin
                        q_d   = '0;
                        err_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (hold) begin
                    state_d = S_PAUSE;
                end else begin
                    q_d         = advNext;
                    wrap_d      = (advNext == '0);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_PAUSE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Q    = q_q;
    assign busy = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done = (state_q == S_DONE);
    assign wrap = wrap_q;
    assign err  = err_q;

`ifdef JC_PHASE_DECODE_EN
    // Each phase is identified by where its single 1/0 boundary sits, or by both ends for the all-0/all-1 phases.
    always_comb begin
        phase_oh = '0;
        if (qLegal) begin
            phase_oh[0]    = ~q_q[BITS-1] & ~q_q[0];
            phase_oh[BITS] =  q_q[BITS-1] &  q_q[0];
            for (int k = 1; k < BITS; k++) begin
                phase_oh[k]      =  q_q[BITS-k] & ~q_q[BITS-k-1];
                phase_oh[BITS+k] = ~q_q[BITS-k] &  q_q[BITS-k-1];
            end
        end
    end
`else
    logic unusedLegal;
    assign unusedLegal = qLegal;
`endif

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl: directed scenarios then random traffic against a phase-index model.
// Checks phase_oh as well when JC_PHASE_DECODE_EN is defined.
module tb_johnson_seq_ctrl;

    localparam int BITS  = 4;
    localparam int CNT_W = 8;
    localparam int IDX_W = $clog2(2*BITS);
    localparam int NPH   = 2 * BITS;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] steps;
    logic             hold;
    logic             abort;
    logic             load;
    logic [BITS-1:0]  load_val;
    logic             err_clr;
    logic [BITS-1:0]  Q;
    logic [IDX_W-1:0] phase_idx;
    logic             busy;
    logic             done;
    logic             wrap;
    logic             err;
`ifdef JC_PHASE_DECODE_EN
    logic [NPH-1:0]   phase_oh;
`endif

    int compareCount = 0;
    int failCount    = 0;

    int   mIdx;
    int   mMode;
    int   mRem;
    logic mDir;
    logic mWrap;
    logic mErr;

    johnson_seq_ctrl #(.BITS(BITS), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dir       (dir),
        .steps     (steps),
        .hold      (hold),
        .abort     (abort),
        .load      (load),
        .load_val  (load_val),
        .err_clr   (err_clr),
        .Q         (Q),
        .phase_idx (phase_idx),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
`ifdef JC_PHASE_DECODE_EN
        .phase_oh  (phase_oh),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    // Phase k of the ring: the first BITS+1 phases fill ones in from the MSB, the rest drain them from the MSB.
    function automatic logic [BITS-1:0] qOf(input int idx);
        logic [BITS-1:0] v;
        v = '0;
        for (int b = 0; b < BITS; b++) begin
            if (idx <= BITS) begin
                v[b] = (b >= BITS - idx);
            end else begin
                v[b] = (b < BITS - (idx - BITS));
            end
        end
        return v;
    endfunction

    // A value is legal exactly when it appears somewhere in the phase table.
    function automatic int indexOf(input logic [BITS-1:0] v);
        for (int k = 0; k < NPH; k++) begin
            if (qOf(k) == v) begin
                return k;
            end
        end
        return -1;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".Q"},         32'(Q),         32'(qOf(mIdx)));
        checkValue({tag, ".phase_idx"}, 32'(phase_idx), 32'(mIdx));
        checkValue({tag, ".busy"},      32'(busy),      32'((mMode == M_RUN) || (mMode == M_PAUSE)));
        checkValue({tag, ".done"},      32'(done),      32'(mMode == M_DONE));
        checkValue({tag, ".wrap"},      32'(wrap),      32'(mWrap));
        checkValue({tag, ".err"},       32'(err),       32'(mErr));
`ifdef JC_PHASE_DECODE_EN
        checkValue({tag, ".phase_oh"},  32'(phase_oh),  32'(1) << mIdx);
`endif
    endtask

    task automatic modelReset();
        mIdx  = 0;
        mMode = M_IDLE;
        mRem  = 0;
        mDir  = 1'b0;
        mWrap = 1'b0;
        mErr  = 1'b0;
    endtask

    task automatic modelEdge();
        logic nextWrap;
        logic errSet;
        nextWrap = 1'b0;
        errSet   = 1'b0;
        case (mMode)
            M_IDLE: begin
                if (start) begin
                    if (steps != 0) begin
                        mRem  = int'(steps);
                        mDir  = dir;
                        mMode = M_RUN;
                    end else begin
                        mMode = M_DONE;
                    end
                end else if (load) begin
                    if (indexOf(load_val) >= 0) begin
                        mIdx = indexOf(load_val);
                    end else begin
                        mIdx   = 0;
                        errSet = 1'b1;
                    end
                end
            end
            M_RUN: begin
                if (abort) begin
                    mMode = M_IDLE;
                end else if (hold) begin
                    mMode = M_PAUSE;
                end else begin
                    mIdx     = mDir ? (mIdx + NPH - 1) % NPH : (mIdx + 1) % NPH;
                    nextWrap = (mIdx == 0);
                    mRem     = mRem - 1;
                    if (mRem == 0) begin
                        mMode = M_DONE;
                    end
                end
            end
            M_PAUSE: begin
                if (abort) begin
                    mMode = M_IDLE;
                end else if (!hold) begin
                    mMode = M_RUN;
                end
            end
            default: begin
                mMode = M_IDLE;
            end
        endcase
        mWrap = nextWrap;
        if (errSet) begin
            mErr = 1'b1;
        end else if (err_clr) begin
            mErr = 1'b0;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic s, input logic d, input int n,
                                 input logic h, input logic a, input logic l,
                                 input logic [BITS-1:0] lv, input logic ec);
        start    = s;
        dir      = d;
        steps    = CNT_W'(n);
        hold     = h;
        abort    = a;
        load     = l;
        load_val = lv;
        err_clr  = ec;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    task automatic idleTick(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic resetPulse(input string tag);
        reset_n = 1'b0;
        #2;
        modelReset();
        checkOutput(tag);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        dir      = 1'b0;
        steps    = '0;
        hold     = 1'b0;
        abort    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        err_clr  = 1'b0;
        modelReset();
        resetPulse("reset");

        // Reset mid-run after two forward advances.
        applyStimulus("rm_start", 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        idleTick("rm_adv1");
        idleTick("rm_adv2");
        resetPulse("rm_reset");
        idleTick("rm_after");

        // Forward full cycle.
        applyStimulus("fwd_start", 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idleTick("fwd_adv");
        end
        idleTick("fwd_idle");

        // Reverse run with a two-cycle hold after the first advance.
        applyStimulus("rev_load", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0);
        applyStimulus("rev_start", 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        idleTick("rev_adv1");
        applyStimulus("rev_hold1", 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        applyStimulus("rev_hold2", 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        idleTick("rev_resume");
        idleTick("rev_adv2");
        idleTick("rev_adv3");
        idleTick("rev_idle");

        // Abort during PAUSE, then a zero-step start.
        applyStimulus("ab_load", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
        applyStimulus("ab_start", 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        idleTick("ab_adv");
        applyStimulus("ab_hold", 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        applyStimulus("ab_abort", 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        applyStimulus("zero_start", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        idleTick("zero_idle");

        // Illegal load, sticky err, clear, set-wins, load ignored during RUN.
        applyStimulus("err_bad", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 4'b0101, 1'b0);
        applyStimulus("err_sticky", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0);
        applyStimulus("err_clr", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        applyStimulus("err_setwins", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1);
        applyStimulus("err_clr2", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        applyStimulus("run_start", 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0);
        applyStimulus("run_load1", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0);
        applyStimulus("run_load2", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0);
        idleTick("run_adv3");
        idleTick("run_adv4");
        applyStimulus("done_load", 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0);
        idleTick("run_idle");

        // Reverse wrap into phase 0 from phase 1.
        applyStimulus("rw_load", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0);
        applyStimulus("rw_start", 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        idleTick("rw_adv1");
        idleTick("rw_adv2");
        idleTick("rw_idle");

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                resetPulse("rnd_reset");
            end else begin
                applyStimulus("rnd",
                              ($urandom_range(0, 99) < 30),
                              1'($urandom_range(0, 1)),
                              int'($urandom_range(0, 12)),
                              ($urandom_range(0, 99) < 20),
                              ($urandom_range(0, 99) < 4),
                              ($urandom_range(0, 99) < 25),
                              4'($urandom_range(0, 15)),
                              ($urandom_range(0, 99) < 10));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
